rca_word_sequencer: RTL and testbench

Multi-cycle controller that adds two wide operands (N*WORDS bits) on a single shared N-bit `rca` instance, one N-bit word per cycle, least-significant word first. It chains the carry between words through a register. It sits between a valid/ready producer and consumer and owns the only `rca` it drives, so wide additions reuse one narrow adder instead of a WORDS-wide ripple chain.

---
 rtl/rca_word_sequencer.sv | 87 ++++++++
 tb/tb_rca_word_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: adds two N*WORDS-bit operands on one shared N-bit ripple-carry slice, one word per cycle
module rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  assign cout = c[N];
  for (genvar g = 0; g < N; g++) begin : g_bit
    assign sum[g]  = a[g] ^ b[g] ^ c[g];
    assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
endmodule

module rca_word_sequencer #(
  parameter int N = 8,
  parameter int WORDS = 4,
  localparam int W = N * WORDS,
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] A_in,
  input  logic [W-1:0] B_in,
  input  logic         Cin,
  output logic [W-1:0] Sum_out,
  output logic         Cout_out,
  output logic         done_valid,
  input  logic         done_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [W-1:0] a_q, b_q;
  logic carry_q;
  logic [IW-1:0] idx;
  logic [N-1:0] s;
  logic co;
  logic last;
  assign last = idx == IW'(WORDS - 1);
  rca #(.N(N)) u_rca (
    .a(a_q[N*idx +: N]),
    .b(b_q[N*idx +: N]),
    .cin(carry_q),
    .sum(s),
    .cout(co)
  );
  assign start_ready = state == IDLE;
  assign busy = state == RUN;
  assign done_valid = state == DONE;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : next;
  always_comb begin
    next = state;
    next = state == IDLE ? (start_valid ? RUN : IDLE)
         : state == RUN  ? (last ? DONE : RUN)
         : (done_ready ? IDLE : DONE);
  end
  // Operands latch only on accept, so producer activity during RUN/DONE cannot disturb the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      idx <= '0;
      Sum_out <= '0;
      Cout_out <= 1'b0;
    end else if (state == IDLE && start_valid) begin
      a_q <= A_in;
      b_q <= B_in;
      carry_q <= Cin;
      idx <= '0;
      Sum_out <= '0;
    end else if (state == RUN) begin
      Sum_out[N*idx +: N] <= s;
      carry_q <= co;
      if (last) Cout_out <= co;
      else idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: directed checks on the default build plus a random sweep over four geometries
module tb_rca_word_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic done_ready = 1'b0;
  logic cin = 1'b0;
  logic [63:0] a_bus = '0, b_bus = '0;
  logic [3:0] sr, dv, bz, co;
  logic [31:0] s0;
  logic [7:0] s1;
  logic [63:0] s2, s3;
  logic [65:0] r[4];
  int checks = 0, failures = 0;
  int wbits[4] = '{32, 8, 64, 64};
  int words[4] = '{4, 1, 8, 4};

  always #5 clk = ~clk;

  rca_word_sequencer #(.N(8), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[0]),
    .A_in(a_bus[31:0]), .B_in(b_bus[31:0]), .Cin(cin), .Sum_out(s0), .Cout_out(co[0]),
    .done_valid(dv[0]), .done_ready(done_ready), .busy(bz[0]));
  rca_word_sequencer #(.N(8), .WORDS(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[1]),
    .A_in(a_bus[7:0]), .B_in(b_bus[7:0]), .Cin(cin), .Sum_out(s1), .Cout_out(co[1]),
    .done_valid(dv[1]), .done_ready(done_ready), .busy(bz[1]));
  rca_word_sequencer #(.N(8), .WORDS(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[2]),
    .A_in(a_bus), .B_in(b_bus), .Cin(cin), .Sum_out(s2), .Cout_out(co[2]),
    .done_valid(dv[2]), .done_ready(done_ready), .busy(bz[2]));
  rca_word_sequencer #(.N(16), .WORDS(4)) d16 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr[3]),
    .A_in(a_bus), .B_in(b_bus), .Cin(cin), .Sum_out(s3), .Cout_out(co[3]),
    .done_valid(dv[3]), .done_ready(done_ready), .busy(bz[3]));

  assign r[0] = {33'b0, co[0], s0};
  assign r[1] = {57'b0, co[1], s1};
  assign r[2] = {1'b0, co[2], s2};
  assign r[3] = {1'b0, co[3], s3};

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_valid = 1'b0;
    done_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".start_ready"}, 66'(sr[0]), 66'd1);
    check({tag, ".done_valid"}, 66'(dv[0]), 66'd0);
    check({tag, ".busy"}, 66'(bz[0]), 66'd0);
    check({tag, ".sum"}, 66'(s0), 66'd0);
    check({tag, ".cout"}, 66'(co[0]), 66'd0);
  endtask

  // Accept one add on the default build, scramble producer inputs during RUN, hold DONE for hold cycles
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] exp, input int hold);
    int lat;
    logic [32:0] seen;
    @(negedge clk);
    a_bus = {32'b0, a};
    b_bus = {32'b0, b};
    cin = c;
    start_valid = 1'b1;
    done_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 1;
    while (!dv[0] && lat < 20) begin
      a_bus = {$urandom, $urandom};
      cin = ~cin;
      start_valid = ~start_valid;
      @(negedge clk);
      lat++;
    end
    start_valid = 1'b0;
    check({tag, ".latency"}, 66'(lat), 66'd5);
    check({tag, ".result"}, 66'({co[0], s0}), 66'(exp));
    seen = {co[0], s0};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 66'(dv[0]), 66'd1);
      check({tag, ".hold_result"}, 66'({co[0], s0}), 66'(seen));
      check({tag, ".hold_ready"}, 66'(sr[0]), 66'd0);
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check({tag, ".ready_after"}, 66'(sr[0]), 66'd1);
    check({tag, ".valid_after"}, 66'(dv[0]), 66'd0);
  endtask

  initial begin
    do_reset();
    check_idle("reset");
    run_op("zero", 32'h0, 32'h0, 1'b0, 33'h0_0000_0000, 0);
    run_op("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 0);
    run_op("carry_word", 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 0);
    run_op("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_678A, 0);
    run_op("backpressure", 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 33'h1_0000_0001, 10);
    @(negedge clk);
    a_bus = 64'hAA;
    b_bus = 64'h55;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    check("midrun.busy", 66'(bz[0]), 66'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrun_reset");
    run_op("after_reset", 32'd5, 32'd10, 1'b0, 33'h0_0000_000F, 0);
    do_reset();
    check("sweep.all_ready", 66'(sr), 66'hF);
    for (int it = 0; it < 200; it++) begin
      int first[4], busyc[4];
      logic [65:0] got[4];
      @(negedge clk);
      a_bus = {$urandom, $urandom};
      b_bus = {$urandom, $urandom};
      cin = 1'($urandom);
      start_valid = 1'b1;
      done_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        first[i] = 0;
        busyc[i] = 0;
        got[i] = '0;
      end
      @(negedge clk);
      start_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (dv[i] && first[i] == 0) begin
            first[i] = c;
            got[i] = r[i];
          end
          if (bz[i]) busyc[i]++;
        end
        @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        logic [65:0] m, e;
        m = (66'd1 << wbits[i]) - 66'd1;
        e = (66'(a_bus) & m) + (66'(b_bus) & m) + 66'(cin);
        check($sformatf("sweep%0d.result", i), got[i], e);
        check($sformatf("sweep%0d.latency", i), 66'(first[i]), 66'(words[i] + 1));
        check($sformatf("sweep%0d.busy", i), 66'(busyc[i]), 66'(words[i]));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
